// File: rtl/qracc_csr_responder.sv
// qracc_csr_responder: QRAcc CSR bus responder; QRACC_CSR_PERF_COUNTER_EN adds the CSR7 busy-cycle counter
package qracc_csr_pkg;
  typedef struct packed {
    logic [31:0] data_in;
    logic [31:0] addr;
    logic        wen;
    logic        valid;
  } bus_req_t;
  typedef struct packed {
    logic        ready;
    logic [31:0] data_out;
    logic        rd_data_valid;
  } bus_resp_t;
  typedef logic [2:0] qracc_trigger_t;
  localparam qracc_trigger_t TRIGGER_IDLE = 3'd0;
  typedef struct packed {
    logic        binary_cfg;
    logic        unsigned_acts;
    logic [3:0]  adc_ref_range_shifts;
    logic [3:0]  filter_size_y;
    logic [3:0]  filter_size_x;
    logic [3:0]  stride_x;
    logic [3:0]  stride_y;
    logic [3:0]  n_input_bits_cfg;
    logic [3:0]  n_output_bits_cfg;
    logic [15:0] ifmap_dimx;
    logic [15:0] ifmap_dimy;
    logic [15:0] ofmap_dimx;
    logic [15:0] ofmap_dimy;
    logic [15:0] n_input_channels;
    logic [15:0] n_output_channels;
    logic [15:0] mapped_matrix_offset_x;
    logic [15:0] mapped_matrix_offset_y;
    logic [3:0]  padding;
    logic [7:0]  padding_value;
    logic        preserve_ifmap;
  } qracc_config_t;
endpackage

module qracc_csr_responder
  import qracc_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          CFG_LOCK  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  bus_req_t       bus_req_i,
  output bus_resp_t      bus_resp_o,
  input  logic           busy_i,
  input  logic [3:0]     ctrl_state_i,
  output qracc_config_t  cfg_o,
  output qracc_trigger_t trigger_o,
  output logic           clear_o,
  output logic           inst_write_mode_o
);
  localparam qracc_config_t CFG_RST = '{stride_x: 4'd1, stride_y: 4'd1, default: '0};
  logic [31:0] off, d, rd_val, rd_data_q;
  logic [2:0] idx;
  logic hit, ready, acc, wr, rd, wr0, cfg_wr, clr_d;
  logic rdy_q, rd_valid_q, clear_q, iwm_q;
  qracc_trigger_t trigger_q, trig_d;
  qracc_config_t cfg_q, cfg_d;
  logic [31:0] perf;
  assign off    = bus_req_i.addr - BASE_ADDR;
  assign hit    = off < 32'd32;
  assign idx    = off[4:2];
  assign d      = bus_req_i.data_in;
  assign ready  = rdy_q & ~rd_valid_q;
  assign acc    = bus_req_i.valid & ready;
  assign wr     = acc & bus_req_i.wen & hit;
  assign rd     = acc & ~bus_req_i.wen;
  assign wr0    = wr && idx == 3'd0;
  assign cfg_wr = wr && idx != 3'd0 && idx != 3'd7 && !(CFG_LOCK && busy_i);
  assign clr_d  = wr0 & d[3];
  assign trig_d = (wr0 && d[2:0] != 3'd0 && !busy_i && !d[3]) ? qracc_trigger_t'(d[2:0]) : TRIGGER_IDLE;
`ifdef QRACC_CSR_PERF_COUNTER_EN
  logic [31:0] perf_q;
  // clear zeroes the counter both at the write edge and during the pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) perf_q <= '0;
    else if (clr_d || clear_q) perf_q <= '0;
    else if (busy_i && perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
  assign perf = perf_q;
`else
  assign perf = '0;
`endif
  always_comb begin
    cfg_d = cfg_q;
    if (wr0) cfg_d.preserve_ifmap = d[12];
    if (cfg_wr)
      case (idx)
        3'd1: begin
          cfg_d.binary_cfg           = d[0];
          cfg_d.unsigned_acts        = d[1];
          cfg_d.adc_ref_range_shifts = d[7:4];
          cfg_d.filter_size_y        = d[11:8];
          cfg_d.filter_size_x        = d[15:12];
          cfg_d.stride_x             = d[19:16];
          cfg_d.stride_y             = d[23:20];
          cfg_d.n_input_bits_cfg     = d[27:24];
          cfg_d.n_output_bits_cfg    = d[31:28];
        end
        3'd2: {cfg_d.ifmap_dimy, cfg_d.ifmap_dimx} = d;
        3'd3: {cfg_d.ofmap_dimy, cfg_d.ofmap_dimx} = d;
        3'd4: {cfg_d.n_output_channels, cfg_d.n_input_channels} = d;
        3'd5: {cfg_d.mapped_matrix_offset_y, cfg_d.mapped_matrix_offset_x} = d;
        3'd6: {cfg_d.padding_value, cfg_d.padding} = d[11:0];
        default: ;
      endcase
  end
  always_comb begin
    rd_val = '0;
    if (hit)
      case (idx)
        3'd0: rd_val = {19'd0, cfg_q.preserve_ifmap, ctrl_state_i, 2'd0, iwm_q, busy_i, 4'd0};
        3'd1: rd_val = {cfg_q.n_output_bits_cfg, cfg_q.n_input_bits_cfg, cfg_q.stride_y, cfg_q.stride_x,
                        cfg_q.filter_size_x, cfg_q.filter_size_y, cfg_q.adc_ref_range_shifts, 2'd0,
                        cfg_q.unsigned_acts, cfg_q.binary_cfg};
        3'd2: rd_val = {cfg_q.ifmap_dimy, cfg_q.ifmap_dimx};
        3'd3: rd_val = {cfg_q.ofmap_dimy, cfg_q.ofmap_dimx};
        3'd4: rd_val = {cfg_q.n_output_channels, cfg_q.n_input_channels};
        3'd5: rd_val = {cfg_q.mapped_matrix_offset_y, cfg_q.mapped_matrix_offset_x};
        3'd6: rd_val = {20'd0, cfg_q.padding_value, cfg_q.padding};
        default: rd_val = perf;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdy_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      trigger_q  <= TRIGGER_IDLE;
      clear_q    <= 1'b0;
      iwm_q      <= 1'b0;
      cfg_q      <= CFG_RST;
    end else begin
      rdy_q      <= 1'b1;
      rd_valid_q <= rd;
      rd_data_q  <= rd ? rd_val : '0;
      trigger_q  <= trig_d;
      clear_q    <= clr_d;
      if (wr0) iwm_q <= d[5];
      cfg_q      <= cfg_d;
    end
  assign bus_resp_o = '{ready: ready, data_out: rd_valid_q ? rd_data_q : 32'd0, rd_data_valid: rd_valid_q};
  assign cfg_o             = cfg_q;
  assign trigger_o         = trigger_q;
  assign clear_o           = clear_q;
  assign inst_write_mode_o = iwm_q;
endmodule

// File: tb/tb_qracc_csr_responder.sv
// tb_qracc_csr_responder: directed checks of the QRAcc CSR responder
module tb_qracc_csr_responder;
  import qracc_csr_pkg::*;
  logic clk = 1'b0, rst = 1'b1, busy = 1'b0, clear, iwm;
  logic [3:0] state = 4'h5;
  bus_req_t req = '0;
  bus_resp_t resp;
  qracc_config_t cfg;
  qracc_trigger_t trig;
  int checks = 0, errors = 0;
  qracc_csr_responder dut (
    .clk(clk), .rst(rst), .bus_req_i(req), .bus_resp_o(resp), .busy_i(busy),
    .ctrl_state_i(state), .cfg_o(cfg), .trigger_o(trig), .clear_o(clear), .inst_write_mode_o(iwm)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] dt);
    @(negedge clk);
    req = '{data_in: dt, addr: a, wen: 1'b1, valid: 1'b1};
    @(negedge clk);
    req = '0;
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    req = '{data_in: 32'd0, addr: a, wen: 1'b0, valid: 1'b1};
    chk({tag, "_ready_pre"}, 32'(resp.ready), 32'd1);
    @(negedge clk);
    req = '0;
    chk({tag, "_rdv"}, 32'(resp.rd_data_valid), 32'd1);
    chk({tag, "_data"}, resp.data_out, exp);
    chk({tag, "_ready_busy"}, 32'(resp.ready), 32'd0);
    @(negedge clk);
    chk({tag, "_rdv_drop"}, 32'(resp.rd_data_valid), 32'd0);
    chk({tag, "_data_zero"}, resp.data_out, 32'd0);
    chk({tag, "_ready_back"}, 32'(resp.ready), 32'd1);
  endtask
  initial begin
    #12;
    chk("rst_ready", 32'(resp.ready), 32'd0);
    chk("rst_rdv", 32'(resp.rd_data_valid), 32'd0);
    chk("rst_data", resp.data_out, 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_clear", 32'(clear), 32'd0);
    chk("rst_iwm", 32'(iwm), 32'd0);
    chk("rst_stride_x", 32'(cfg.stride_x), 32'd1);
    chk("rst_stride_y", 32'(cfg.stride_y), 32'd1);
    chk("rst_ifmap_dimx", 32'(cfg.ifmap_dimx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(resp.ready), 32'd0);
    @(negedge clk);
    chk("ready_rises", 32'(resp.ready), 32'd1);
    rd_chk("csr1_reset", 32'h04, 32'h0011_0000);
    wr(32'h04, 32'h8411_1230);
    chk("cfg_adc", 32'(cfg.adc_ref_range_shifts), 32'd3);
    chk("cfg_fy", 32'(cfg.filter_size_y), 32'd2);
    chk("cfg_nout", 32'(cfg.n_output_bits_cfg), 32'd8);
    chk("cfg_nin", 32'(cfg.n_input_bits_cfg), 32'd4);
    rd_chk("csr1", 32'h04, 32'h8411_1230);
    wr(32'h04, 32'hFFFF_FFFF);
    chk("cfg_binary", 32'(cfg.binary_cfg), 32'd1);
    rd_chk("csr1_unused", 32'h04, 32'hFFFF_FFF3);
    wr(32'h00, 32'h0000_0003);
    chk("trig_pulse", 32'(trig), 32'd3);
    chk("trig_noclear", 32'(clear), 32'd0);
    @(negedge clk);
    chk("trig_end", 32'(trig), 32'd0);
    rd_chk("csr0_trig_wo", 32'h00, 32'h0000_0500);
    wr(32'h00, 32'h0000_1020);
    chk("iwm_set", 32'(iwm), 32'd1);
    chk("preserve_set", 32'(cfg.preserve_ifmap), 32'd1);
    chk("no_trig_zero", 32'(trig), 32'd0);
    rd_chk("csr0_rw", 32'h00, 32'h0000_1520);
    busy = 1'b1;
    wr(32'h08, 32'h0010_0020);
    chk("lock_dimx", 32'(cfg.ifmap_dimx), 32'd0);
    chk("lock_dimy", 32'(cfg.ifmap_dimy), 32'd0);
    wr(32'h00, 32'h0000_0001);
    chk("busy_trig", 32'(trig), 32'd0);
    @(negedge clk);
    chk("busy_trig_late", 32'(trig), 32'd0);
    rd_chk("csr0_busy", 32'h00, 32'h0000_0510);
    busy = 1'b0;
    wr(32'h08, 32'h0010_0020);
    chk("dimx", 32'(cfg.ifmap_dimx), 32'h20);
    chk("dimy", 32'(cfg.ifmap_dimy), 32'h10);
    wr(32'h00, 32'h0000_000B);
    chk("clear_pulse", 32'(clear), 32'd1);
    chk("clear_kills_trig", 32'(trig), 32'd0);
    @(negedge clk);
    chk("clear_end", 32'(clear), 32'd0);
    chk("clear_trig_late", 32'(trig), 32'd0);
    chk("clear_keeps_cfg", 32'(cfg.ifmap_dimx), 32'h20);
    wr(32'h0E, 32'h0003_0004);
    chk("ofmap_dimx", 32'(cfg.ofmap_dimx), 32'd4);
    chk("ofmap_dimy", 32'(cfg.ofmap_dimy), 32'd3);
    wr(32'h18, 32'hFFFF_FFFF);
    chk("padding", 32'(cfg.padding), 32'hF);
    chk("padding_value", 32'(cfg.padding_value), 32'hFF);
    rd_chk("csr6", 32'h18, 32'h0000_0FFF);
    wr(32'h10, 32'h0040_0008);
    wr(32'h14, 32'h0002_0001);
    rd_chk("csr4", 32'h10, 32'h0040_0008);
    rd_chk("csr5", 32'h14, 32'h0002_0001);
    wr(32'h24, 32'h0000_0000);
    rd_chk("oow_write_ignored", 32'h04, 32'hFFFF_FFF3);
    rd_chk("oow_read", 32'h40, 32'd0);
    @(negedge clk);
    req = '{data_in: 32'd0, addr: 32'h08, wen: 1'b0, valid: 1'b1};
    @(negedge clk);
    chk("b2b_rdv1", 32'(resp.rd_data_valid), 32'd1);
    chk("b2b_data1", resp.data_out, 32'h0010_0020);
    chk("b2b_ready_low", 32'(resp.ready), 32'd0);
    req.addr = 32'h0C;
    @(negedge clk);
    chk("b2b_gap", 32'(resp.rd_data_valid), 32'd0);
    chk("b2b_ready_back", 32'(resp.ready), 32'd1);
    @(negedge clk);
    req = '0;
    chk("b2b_rdv2", 32'(resp.rd_data_valid), 32'd1);
    chk("b2b_data2", resp.data_out, 32'h0003_0004);
`ifdef QRACC_CSR_PERF_COUNTER_EN
    wr(32'h00, 32'h0000_0008);
    @(negedge clk);
    busy = 1'b1;
    repeat (10) @(negedge clk);
    busy = 1'b0;
    wr(32'h1C, 32'h0000_1234);
    rd_chk("perf_10", 32'h1C, 32'd10);
    wr(32'h00, 32'h0000_0008);
    rd_chk("perf_cleared", 32'h1C, 32'd0);
`else
    wr(32'h1C, 32'h0000_1234);
    rd_chk("csr7_zero", 32'h1C, 32'd0);
`endif
    @(negedge clk);
    req = '{data_in: 32'd0, addr: 32'h04, wen: 1'b0, valid: 1'b1};
    @(negedge clk);
    req = '0;
    chk("midrd_rdv", 32'(resp.rd_data_valid), 32'd1);
    #1 rst = 1'b1;
    #1 chk("midrd_rdv_drop", 32'(resp.rd_data_valid), 32'd0);
    chk("midrd_data", resp.data_out, 32'd0);
    chk("midrd_ready", 32'(resp.ready), 32'd0);
    chk("midrd_cfg_rst", 32'(cfg.n_output_bits_cfg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrd_ready_back", 32'(resp.ready), 32'd1);
    chk("midrd_no_stale", 32'(resp.rd_data_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
